// File: rtl/spike_packet_tx_if.sv
// Spike-in / flit-out channels of the spike transmitter; the master modport is the transmitter side.
// Both channels use valid/ready handshakes; the transmitter drives spike_ready and the flit bus.
interface spike_packet_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  spike_valid;
    logic [7:0]            spike_id;
    logic                  spike_ready;
    logic [DATA_WIDTH-1:0] flit_out;
    logic                  flit_valid;
    logic                  flit_ready;

    modport master (
        input  spike_valid, spike_id, flit_ready,
        output spike_ready, flit_out, flit_valid
    );

    modport slave (
        output spike_valid, spike_id, flit_ready,
        input  spike_ready, flit_out, flit_valid
    );
endinterface

// File: rtl/spike_packet_tx.sv
// Spike transmitter: FIFOs neuron spikes, looks up a per-neuron destination and emits 32-bit NoC flits.
// Latency: spike accepted at edge N into an empty FIFO gives flit_valid after edge N+1; SPIKE_TX_TIMESTAMP_EN adds a cycle-stamp tag.
// Backpressure: flit held bit-stable while !flit_ready; spike_ready drops when the registered count is full.

module spike_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Caller guarantees no push when full and no pop when empty; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module spike_packet_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_NEURONS = 4,
    parameter int FIFO_DEPTH  = 8,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            node_x,
    input  logic [3:0]            node_y,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_addr,
    input  logic [7:0]            cfg_dest,
    input  logic                  cfg_en,
    spike_packet_tx_if.master     tx,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [15:0]           drop_count
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int TBL_N = 1 << IDX_W;
`ifdef SPIKE_TX_TIMESTAMP_EN
    localparam int ENT_W = 16;
`else
    localparam int ENT_W = 8;
`endif

    typedef enum logic {ST_EMPTY, ST_LOADED} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] flit_q, flit_d;
    logic [15:0]           drop_q, drop_d;
    logic [16:0]           drop_sum;
    logic [8:0]            tbl_q [TBL_N];   // {en, dest_x, dest_y}
    logic [8:0]            tbl_d [TBL_N];

    logic             spike_ready, id_ok, cfg_ok, accept, push, pop, load_flit, can_load;
    logic [ENT_W-1:0] push_dat, head_dat;
    logic [CNT_W-1:0] fifo_cnt;
    logic [7:0]       head_id, head_tag;
    logic [8:0]       head_ent;

`ifdef SPIKE_TX_TIMESTAMP_EN
    logic [7:0] ts_q, ts_d;
    always_comb ts_d = ts_q + 8'd1;
    always_ff @(posedge clk) begin
        if (rst) ts_q <= 8'd0;
        else     ts_q <= ts_d;
    end
    assign push_dat = {ts_q, tx.spike_id};
    assign head_tag = head_dat[15:8];
`else
    assign push_dat = tx.spike_id;
    assign head_tag = 8'h00;
`endif

    // Readiness comes from the registered count only, so a full FIFO never accepts even when popping.
    assign spike_ready = (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign id_ok       = ({1'b0, tx.spike_id} < 9'(NUM_NEURONS));
    assign cfg_ok      = ({1'b0, cfg_addr} < 9'(NUM_NEURONS));
    assign accept      = tx.spike_valid && spike_ready;
    assign push        = accept && id_ok;

    assign head_id   = head_dat[7:0];
    assign head_ent  = tbl_q[head_id[IDX_W-1:0]];
    assign can_load  = (state_q == ST_EMPTY) || tx.flit_ready;
    assign pop       = can_load && (fifo_cnt != '0);
    assign load_flit = pop && head_ent[8];

    spike_tx_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            flit_q  <= '0;
            drop_q  <= '0;
            for (int i = 0; i < TBL_N; i++) tbl_q[i] <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            drop_q  <= drop_d;
            tbl_q   <= tbl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:  if (load_flit) state_d = ST_LOADED;
            ST_LOADED: if (tx.flit_ready) state_d = load_flit ? ST_LOADED : ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    // A disabled head is still popped; it only costs a drop count.
    always_comb begin
        flit_d = flit_q;
        if (load_flit) begin
            flit_d = DATA_WIDTH'({head_ent[7:0], node_x, node_y, head_id, head_tag});
        end
        drop_sum = {1'b0, drop_q} + 17'(accept && !id_ok) + 17'(pop && !head_ent[8]);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        tbl_d    = tbl_q;
        if (cfg_we && cfg_ok) begin
            tbl_d[cfg_addr[IDX_W-1:0]] = {cfg_en, cfg_dest};
        end
    end

    always_comb begin
        tx.flit_valid  = (state_q == ST_LOADED);
        tx.flit_out    = flit_q;
        tx.spike_ready = spike_ready;
        fifo_count     = fifo_cnt;
        drop_count     = drop_q;
    end
endmodule

// File: tb/tb_spike_packet_tx.sv
// Bench for spike_packet_tx: vector table, hand-written corner sequences and a randomized scoreboard run.
module tb_spike_packet_tx;
    localparam int NN = 4;
    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  node_x, node_y;
    logic        cfg_we, cfg_en;
    logic [7:0]  cfg_addr, cfg_dest;
    logic [3:0]  fifo_count;
    logic [15:0] drop_count;
    logic [7:0]  cyc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spike_packet_tx_if #(.DATA_WIDTH(32)) tx ();

    spike_packet_tx #(.DATA_WIDTH(32), .NUM_NEURONS(NN), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .node_x     (node_x),
        .node_y     (node_y),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_dest   (cfg_dest),
        .cfg_en     (cfg_en),
        .tx         (tx),
        .fifo_count (fifo_count),
        .drop_count (drop_count)
    );

    // Free-running cycle count since reset, used as the expected timestamp tag.
    always @(posedge clk) cyc <= rst ? 8'd0 : cyc + 8'd1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] tag_of(input logic [7:0] c);
`ifdef SPIKE_TX_TIMESTAMP_EN
        return c;
`else
        return c & 8'h00;
`endif
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] dx, dy, sx, sy,
                                       input logic [7:0] id, tag);
        return {dx, dy, sx, sy, id, tag};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; tx.spike_valid = 1'b0; tx.flit_ready = 1'b0; cfg_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] id, input logic [3:0] dx, dy, input logic en);
        cfg_we = 1'b1; cfg_addr = id; cfg_dest = {dx, dy}; cfg_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic        cwe;
        logic [7:0]  cid;
        logic [3:0]  dx, dy;
        logic        cen;
        logic [3:0]  nx, ny;
        logic [7:0]  sid;
        logic        exp_vld;
        logic [31:0] exp_flit;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] exp_f[9];
    logic [31:0] exp_q[$];
    logic        tbl_en[NN];
    logic [3:0]  tbl_dx[NN], tbl_dy[NN];
    logic [7:0]  tag, sid;
    logic        got, stall, seen;
    logic [31:0] gflit, held;
    logic [15:0] model_drop;

    initial begin
        rst = 1'b1; node_x = '0; node_y = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_dest = '0;
        cfg_en = 1'b0; tx.spike_valid = 1'b0; tx.spike_id = '0; tx.flit_ready = 1'b0;

        vecs[0] = '{1'b0, 8'd0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 8'd3, 1'b0, 32'h0,         16'd1};
        vecs[1] = '{1'b1, 8'd1, 4'h1, 4'h1, 1'b1, 4'h0, 4'h0, 8'd1, 1'b1, 32'h1100_0100, 16'd1};
        vecs[2] = '{1'b1, 8'd3, 4'h2, 4'h5, 1'b1, 4'h3, 4'h7, 8'd3, 1'b1, 32'h2537_0300, 16'd1};
        vecs[3] = '{1'b1, 8'd0, 4'h4, 4'h4, 1'b1, 4'h4, 4'h4, 8'd0, 1'b1, 32'h4444_0000, 16'd1};
        vecs[4] = '{1'b1, 8'd2, 4'h6, 4'h6, 1'b0, 4'h4, 4'h4, 8'd2, 1'b0, 32'h0,         16'd2};
        vecs[5] = '{1'b1, 8'd0, 4'hF, 4'hF, 1'b1, 4'h9, 4'hA, 8'd5, 1'b0, 32'h0,         16'd3};
        vecs[6] = '{1'b0, 8'd0, 4'h0, 4'h0, 1'b0, 4'h9, 4'hA, 8'd0, 1'b1, 32'hFF9A_0000, 16'd3};
        vecs[7] = '{1'b0, 8'd0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h2, 8'd1, 1'b1, 32'h1112_0100, 16'd3};

        do_reset();
        chk("rst_flit_valid", tx.flit_valid, 1'b0);
        chk("rst_flit_out", tx.flit_out, 32'h0);
        chk("rst_fifo_count", fifo_count, 4'd0);
        chk("rst_drop_count", drop_count, 16'd0);
        chk("rst_spike_ready", tx.spike_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            node_x = vecs[i].nx; node_y = vecs[i].ny;
            if (vecs[i].cwe) cfg_write(vecs[i].cid, vecs[i].dx, vecs[i].dy, vecs[i].cen);
            tx.spike_valid = 1'b1; tx.spike_id = vecs[i].sid; tx.flit_ready = 1'b1;
            tag = tag_of(cyc);
            tick();
            tx.spike_valid = 1'b0;
            got = 1'b0; gflit = '0;
            for (int k = 0; k < 5; k++) begin
                if (tx.flit_valid && !got) begin got = 1'b1; gflit = tx.flit_out; end
                tick();
            end
            chk($sformatf("vec%0d_flit_seen", i), got, vecs[i].exp_vld);
            if (vecs[i].exp_vld) chk($sformatf("vec%0d_flit", i), gflit, vecs[i].exp_flit | {24'h0, tag});
            chk($sformatf("vec%0d_drop", i), drop_count, vecs[i].exp_drop);
        end

        // Latency: accept at edge N, flit valid after N+1.
        do_reset();
        cfg_write(8'd1, 4'h1, 4'h1, 1'b1);
        node_x = 4'h0; node_y = 4'h0;
        tx.spike_valid = 1'b1; tx.spike_id = 8'd1; tx.flit_ready = 1'b1; tag = tag_of(cyc);
        tick();
        tx.spike_valid = 1'b0;
        chk("lat_after_N", tx.flit_valid, 1'b0);
        tick();
        chk("lat_after_N1", tx.flit_valid, 1'b1);
        chk("lat_flit", tx.flit_out, 32'h1100_0100 | {24'h0, tag});

        // Table write on the lookup edge: lookup must use the old entry.
        do_reset();
        cfg_write(8'd2, 4'h7, 4'h7, 1'b1);
        node_x = 4'h5; node_y = 4'h6; tx.flit_ready = 1'b1;
        tx.spike_valid = 1'b1; tx.spike_id = 8'd2; tag = tag_of(cyc);
        tick();
        tx.spike_valid = 1'b0;
        cfg_write(8'd2, 4'h1, 4'h1, 1'b0);
        chk("same_edge_vld", tx.flit_valid, 1'b1);
        chk("same_edge_flit", tx.flit_out, mk(4'h7, 4'h7, 4'h5, 4'h6, 8'd2, tag));
        tick();
        tx.spike_valid = 1'b1; tx.spike_id = 8'd2;
        tick();
        tx.spike_valid = 1'b0;
        tick(); tick();
        chk("same_edge_new_drop", drop_count, 16'd1);

        // Fill: one flit in the output register plus FIFO_DEPTH queued, then drain back to back.
        do_reset();
        for (int k = 0; k < NN; k++) cfg_write(8'(k), 4'(k + 1), 4'(k + 2), 1'b1);
        node_x = 4'h2; node_y = 4'h3; tx.flit_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tx.spike_valid = 1'b1; tx.spike_id = 8'(i % NN);
            exp_f[i] = mk(4'((i % NN) + 1), 4'((i % NN) + 2), 4'h2, 4'h3, 8'(i % NN), tag_of(cyc));
            tick();
        end
        chk("fill_count", fifo_count, 4'd8);
        chk("fill_ready", tx.spike_ready, 1'b0);
        chk("fill_valid", tx.flit_valid, 1'b1);
        tx.spike_id = 8'd0;
        tick();
        tx.spike_valid = 1'b0;
        chk("full_ignore_count", fifo_count, 4'd8);
        chk("full_ignore_drop", drop_count, 16'd0);
        tx.flit_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("drain%0d_vld", i), tx.flit_valid, 1'b1);
            chk($sformatf("drain%0d_flit", i), tx.flit_out, exp_f[i]);
            tick();
        end
        chk("drain_done_vld", tx.flit_valid, 1'b0);
        chk("drain_done_count", fifo_count, 4'd0);

        // Reset while a flit is held and three spikes are queued.
        do_reset();
        cfg_write(8'd1, 4'h3, 4'h3, 1'b1);
        tx.flit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx.spike_valid = 1'b1; tx.spike_id = 8'd1;
            tick();
        end
        tx.spike_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 4'd3);
        chk("pre_rst_valid", tx.flit_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", tx.flit_valid, 1'b0);
        chk("mid_rst_count", fifo_count, 4'd0);
        chk("mid_rst_ready", tx.spike_ready, 1'b1);
        chk("mid_rst_flit", tx.flit_out, 32'h0);
        tx.flit_ready = 1'b1; seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | tx.flit_valid;
            tick();
        end
        chk("post_rst_idle", seen, 1'b0);

        // Randomized run against a transaction-level scoreboard (table fixed during the run).
        do_reset();
        for (int k = 0; k < NN; k++) begin
            tbl_en[k] = ($urandom % 4) != 0;
            tbl_dx[k] = 4'($urandom); tbl_dy[k] = 4'($urandom);
            if (k == 1) tbl_en[k] = 1'b1;
            cfg_write(8'(k), tbl_dx[k], tbl_dy[k], tbl_en[k]);
        end
        node_x = 4'($urandom); node_y = 4'($urandom);
        model_drop = '0; exp_q.delete(); stall = 1'b0; held = '0;
        for (int t = 0; t < 540; t++) begin
            if (stall) begin
                chk("stall_valid", tx.flit_valid, 1'b1);
                chk("stall_hold", tx.flit_out, held);
            end
            if (t < 40)       tx.flit_ready = t[0];
            else if (t < 500) tx.flit_ready = 1'($urandom % 2);
            else              tx.flit_ready = 1'b1;
            if (t < 500) begin
                tx.spike_valid = 1'($urandom % 2);
                tx.spike_id    = 8'($urandom_range(0, 5));
            end else begin
                tx.spike_valid = 1'b0;
            end
            if (tx.flit_valid && tx.flit_ready) begin
                chk("rnd_flit_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("rnd_flit", tx.flit_out, exp_q.pop_front());
            end
            if (tx.spike_valid && tx.spike_ready) begin
                sid = tx.spike_id;
                if (sid >= NN || !tbl_en[sid[1:0]]) model_drop++;
                else exp_q.push_back(mk(tbl_dx[sid[1:0]], tbl_dy[sid[1:0]], node_x, node_y,
                                        sid, tag_of(cyc)));
            end
            stall = tx.flit_valid && !tx.flit_ready;
            held  = tx.flit_out;
            tick();
        end
        chk("rnd_all_delivered", exp_q.size(), 32'd0);
        chk("rnd_drop_count", drop_count, model_drop);
        chk("rnd_idle_valid", tx.flit_valid, 1'b0);
        chk("rnd_idle_count", fifo_count, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
